debounce_edge: RTL and testbench

- Conditions a raw asynchronous level, such as a push-button or external strobe, before it drives the `d` input of the downstream reset flip-flop stage.
- Synchronises the level into `clk`, then filters it with a counter-based stable-time debounce FSM.
- Outputs a clean level `d_db` plus single-cycle `rise` and `fall` pulses.
- Sits directly upstream of the `d_ff_reset` storage stage.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 22 ++
 rtl/debounce_edge.sv | 119 +++++++++++
 tb/tb_debounce_edge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce / edge-detect front end.
package debounce_pkg;

   // Bit 0 = level being waited for / held, encoding keeps busy = ^state.
   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      WAIT_HI = 2'b01,
      IDLE_HI = 2'b11,
      WAIT_LO = 2'b10
   } db_state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop level synchroniser; no filtering, reused for any async input.
module sync_2ff
   import debounce_pkg::*;
#(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= {SYNC_STAGES{RESET_LEVEL}};
      else       sr <= {sr[SYNC_STAGES-2:0], d};
   end

   assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronise + stable-time debounce of a raw level, with rise/fall pulses.
// Optional push-on/push-off latch on toggle_q when DEBOUNCE_TOGGLE_EN is defined.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int   CNT_W         = 4,
   parameter int   STABLE_CYCLES = 10,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic d_db,
   output logic rise,
   output logic fall,
   output logic busy,
   output logic toggle_q
);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W)) begin : g_bad_stable
      $error("debounce_edge: STABLE_CYCLES out of range 1..2**CNT_W");
   end

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam db_state_t        RESET_STATE = RESET_LEVEL ? IDLE_HI : IDLE_LO;

   logic             d_s;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             db_nxt, rise_nxt, fall_nxt, busy_nxt;

   sync_2ff #(.RESET_LEVEL(RESET_LEVEL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (d_in),
      .q     (d_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
         cnt   <= '0;
         d_db  <= RESET_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         d_db  <= db_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = d_db;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LO: begin
            if (d_s) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = '0;
            end
         end
         WAIT_HI: begin
            if (!d_s) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
               db_nxt    = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         IDLE_HI: begin
            if (!d_s) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = '0;
            end
         end
         WAIT_LO: begin
            if (d_s) begin
               state_nxt = IDLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LO;
               cnt_nxt   = '0;
               db_nxt    = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RESET_STATE;
            cnt_nxt   = '0;
         end
      endcase
      busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
   end

`ifdef DEBOUNCE_TOGGLE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         toggle_q <= 1'b0;
      else if (rise_nxt) toggle_q <= ~toggle_q;
   end
`else
   assign toggle_q = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed scenarios plus randomized levels vs a run-length model.
module tb_debounce_edge;

   localparam int   CNT_W  = 3;
   localparam int   STABLE = 4;
   localparam logic RL     = 1'b0;

   logic clk = 1'b0;
   logic reset;
   logic d_in;
   logic d_db, rise, fall, busy, toggle_q;

   int total = 0;
   int bad   = 0;

   debounce_edge #(.CNT_W(CNT_W), .STABLE_CYCLES(STABLE), .RESET_LEVEL(RL)) dut (
      .clk      (clk),
      .reset    (reset),
      .d_in     (d_in),
      .d_db     (d_db),
      .rise     (rise),
      .fall     (fall),
      .busy     (busy),
      .toggle_q (toggle_q)
   );

   always #10 clk = ~clk;

   // Model: a new level is accepted once the synchronised input has disagreed
   // with the debounced level on STABLE+1 consecutive edges.
   logic ms1 = RL, ms2 = RL, m_db = RL, m_rise = 1'b0, m_fall = 1'b0, m_tog = 1'b0;
   int   m_run = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ms1 = RL; ms2 = RL; m_db = RL; m_run = 0;
         m_rise = 1'b0; m_fall = 1'b0; m_tog = 1'b0;
      end else begin
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (ms2 !== m_db) begin
            m_run++;
            if (m_run == STABLE + 1) begin
               m_db   = ms2;
               m_rise = ms2;
               m_fall = ~ms2;
               m_run  = 0;
`ifdef DEBOUNCE_TOGGLE_EN
               if (ms2) m_tog = ~m_tog;
`endif
            end
         end else begin
            m_run = 0;
         end
         ms2 = ms1;
         ms1 = d_in;
      end
   end

   wire [4:0] obs  = {d_db, rise, fall, busy, toggle_q};
   wire [4:0] expv = {m_db, m_rise, m_fall, (m_run != 0), m_tog};

   task automatic test_reset();
      reset = 1'b1;
      d_in  = 1'bx;
      #5 d_in = 1'b0;
      #7;
      total++;
      if (obs !== 5'b0) begin bad++; $display("FAIL reset_hold got=%b want=00000", obs); end
      #3 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (obs !== 5'b0 || expv !== 5'b0) begin
            bad++; $display("FAIL reset_after cyc=%0d got=%b want=00000", k, obs);
         end
      end
   endtask

   task automatic test_clean_rise();
      int edge_at = 0, nrise = 0, nbusy = 0;
      while ($time < 115) #1;
      d_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (d_db && edge_at == 0) edge_at = k;
         nrise += rise;
         nbusy += busy;
         total++;
         if (obs !== expv) begin bad++; $display("FAIL rise_cyc k=%0d got=%b want=%b", k, obs, expv); end
      end
      total++;
      if (edge_at != STABLE + 3) begin bad++; $display("FAIL rise_latency got=%0d want=%0d", edge_at, STABLE + 3); end
      total++;
      if (nrise != 1) begin bad++; $display("FAIL rise_pulse_len got=%0d want=1", nrise); end
      total++;
      if (nbusy != STABLE) begin bad++; $display("FAIL rise_busy_len got=%0d want=%0d", nbusy, STABLE); end
   endtask

   task automatic test_clean_fall();
      int edge_at = 0, nrise = 0, nfall = 0;
      d_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (!d_db && edge_at == 0) edge_at = k;
         nrise += rise;
         nfall += fall;
         total++;
         if (obs !== expv) begin bad++; $display("FAIL fall_cyc k=%0d got=%b want=%b", k, obs, expv); end
      end
      total++;
      if (edge_at != STABLE + 3) begin bad++; $display("FAIL fall_latency got=%0d want=%0d", edge_at, STABLE + 3); end
      total++;
      if (nfall != 1 || nrise != 0) begin
         bad++; $display("FAIL fall_pulses fall=%0d rise=%0d want fall=1 rise=0", nfall, nrise);
      end
   endtask

   task automatic test_glitch();
      int saw_busy = 0, nrise = 0;
      d_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 d_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         saw_busy |= busy;
         nrise += rise;
         total++;
         if (obs !== expv) begin bad++; $display("FAIL glitch_cyc k=%0d got=%b want=%b", k, obs, expv); end
      end
      total++;
      if (saw_busy != 1 || nrise != 0 || d_db !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_reject busy_seen=%0d rise=%0d d_db=%b busy=%b want 1 0 0 0",
                  saw_busy, nrise, d_db, busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      int found = 0, edge_at = 0;
      d_in = 1'b1;
      for (int k = 0; k < 10 && found == 0; k++) begin
         @(posedge clk); #5;
         if (busy) found = 1;
      end
      total++;
      if (found == 0) begin bad++; $display("FAIL midwait_busy_timeout got=0 want=1"); end
      reset = 1'b1;
      #1;
      total++;
      if (obs !== 5'b0) begin bad++; $display("FAIL midwait_async_clear got=%b want=00000", obs); end
      @(negedge clk); #5 reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (d_db && edge_at == 0) edge_at = k;
         total++;
         if (obs !== expv) begin bad++; $display("FAIL midwait_cyc k=%0d got=%b want=%b", k, obs, expv); end
      end
      total++;
      if (edge_at != STABLE + 3) begin bad++; $display("FAIL midwait_latency got=%0d want=%0d", edge_at, STABLE + 3); end
   endtask

   task automatic test_toggle();
      logic exp_tog;
      int   nrise = 0;
      exp_tog = m_tog;
      for (int p = 0; p < 2; p++) begin
         for (int lvl = 0; lvl < 2; lvl++) begin
            d_in = lvl[0];
            for (int k = 0; k < 9; k++) begin
               @(posedge clk); #1;
               if (rise) begin
                  nrise++;
`ifdef DEBOUNCE_TOGGLE_EN
                  exp_tog = ~exp_tog;
`endif
               end
               total++;
               if (toggle_q !== exp_tog) begin
                  bad++; $display("FAIL toggle p=%0d k=%0d got=%b want=%b", p, k, toggle_q, exp_tog);
               end
            end
         end
      end
      total++;
      if (nrise != 2) begin bad++; $display("FAIL toggle_rises got=%0d want=2", nrise); end
   endtask

   task automatic test_random();
      for (int s = 0; s < 80; s++) begin
         d_in = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 14) == 0) begin
            #3 reset = 1'b1;
            #1;
            total++;
            if (obs !== 5'b0) begin bad++; $display("FAIL rand_reset s=%0d got=%b want=00000", s, obs); end
            @(negedge clk); #3 reset = 1'b0;
         end
         for (int k = $urandom_range(1, 9); k > 0; k--) begin
            @(posedge clk); #1;
            total++;
            if (obs !== expv || (rise && fall)) begin
               bad++; $display("FAIL rand s=%0d got=%b want=%b", s, obs, expv);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_clean_fall();
      test_glitch();
      test_reset_mid_wait();
      test_toggle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
